// File: rtl/axi_ram_wr_mem.sv
// axi_ram_wr_mem: buffers ram_wr_cmd beats in a FIFO, commits them into a byte-strobed RAM, reports burst completion
// Ports: ram_wr_cmd_* beat stream in (en/ready handshake); rd_addr -> rd_data combinational backdoor read;
//        wr_done_valid/wr_done_id completion pulse; beat_count total commits; fifo_level occupancy.
module axi_ram_wr_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH     = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_PERIOD = 0,
  parameter int STALL_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ID_WIDTH-1:0]         ram_wr_cmd_id,
  input  logic [ADDR_WIDTH-1:0]       ram_wr_cmd_addr,
  input  logic [DATA_WIDTH-1:0]       ram_wr_cmd_data,
  input  logic [STRB_WIDTH-1:0]       ram_wr_cmd_strb,
  input  logic                        ram_wr_cmd_en,
  input  logic                        ram_wr_cmd_last,
  output logic                        ram_wr_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        wr_done_valid,
  output logic [ID_WIDTH-1:0]         wr_done_id,
  output logic [31:0]                 beat_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int WW  = ADDR_WIDTH - LSB;
  localparam int PW  = $clog2(FIFO_DEPTH);
  logic [ID_WIDTH-1:0]   f_id   [FIFO_DEPTH];
  logic [WW-1:0]         f_word [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
  logic [STRB_WIDTH-1:0] f_strb [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] f_last;
  logic [DATA_WIDTH-1:0] mem    [2**WW];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [31:0]           stall_cnt;
  logic                  stall_active, push, pop;
  logic                  unused_addr_lsb;
  // byte offset within a word carries no information for a word-wide RAM
  assign unused_addr_lsb  = ^{ram_wr_cmd_addr[LSB-1:0], rd_addr[LSB-1:0]};
  assign stall_active     = STALL_PERIOD > 0 && stall_cnt >= 32'(STALL_PERIOD - STALL_CYCLES);
  // full uses pre-edge occupancy, so a same-edge pop never frees a slot for the push
  assign ram_wr_cmd_ready = fifo_level != (PW+1)'(FIFO_DEPTH) && !stall_active;
  assign push             = ram_wr_cmd_en && ram_wr_cmd_ready;
  assign pop              = fifo_level != '0;
  assign rd_data          = mem[rd_addr[ADDR_WIDTH-1:LSB]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      beat_count    <= '0;
      wr_done_valid <= 1'b0;
      wr_done_id    <= '0;
      stall_cnt     <= '0;
    end else begin
      wr_ptr        <= push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr        <= pop ? rd_ptr + PW'(1) : rd_ptr;
      fifo_level    <= fifo_level + (PW+1)'(push) - (PW+1)'(pop);
      beat_count    <= pop ? beat_count + 32'd1 : beat_count;
      wr_done_valid <= pop && f_last[rd_ptr];
      wr_done_id    <= pop && f_last[rd_ptr] ? f_id[rd_ptr] : wr_done_id;
      stall_cnt     <= STALL_PERIOD == 0 || stall_cnt == 32'(STALL_PERIOD - 1) ? '0 : stall_cnt + 32'd1;
    end
  end
  // storage is never reset: the async-cleared level alone decides what is live
  always_ff @(posedge clk) begin
    if (push) begin
      f_id[wr_ptr]   <= ram_wr_cmd_id;
      f_word[wr_ptr] <= ram_wr_cmd_addr[ADDR_WIDTH-1:LSB];
      f_data[wr_ptr] <= ram_wr_cmd_data;
      f_strb[wr_ptr] <= ram_wr_cmd_strb;
      f_last[wr_ptr] <= ram_wr_cmd_last;
    end
    if (pop)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (f_strb[rd_ptr][i]) mem[f_word[rd_ptr]][i*8 +: 8] <= f_data[rd_ptr][i*8 +: 8];
  end
endmodule

// File: tb/tb_axi_ram_wr_mem.sv
// tb_axi_ram_wr_mem: directed vector bench for axi_ram_wr_mem (no-stall and periodic-stall instances)
module tb_axi_ram_wr_mem;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  id;
  logic [15:0] addr, rd_addr;
  logic [31:0] data;
  logic [3:0]  strb;
  logic        last, en0, en1;
  logic        ready0, ready1, done0, done1;
  logic [7:0]  did0, did1;
  logic [31:0] rd_data0, rd_data1, bc0, bc1;
  logic [2:0]  lvl0, lvl1;
  int checks = 0, errors = 0;
  int dc0 = 0, dc1 = 0, ml0 = 0, ml1 = 0, sc = 0, drops = 0;
  always #5 clk = ~clk;
  axi_ram_wr_mem u0 (
    .clk(clk), .rst_n(rst_n), .ram_wr_cmd_id(id), .ram_wr_cmd_addr(addr), .ram_wr_cmd_data(data),
    .ram_wr_cmd_strb(strb), .ram_wr_cmd_en(en0), .ram_wr_cmd_last(last), .ram_wr_cmd_ready(ready0),
    .rd_addr(rd_addr), .rd_data(rd_data0), .wr_done_valid(done0), .wr_done_id(did0),
    .beat_count(bc0), .fifo_level(lvl0));
  axi_ram_wr_mem #(.STALL_PERIOD(4), .STALL_CYCLES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .ram_wr_cmd_id(id), .ram_wr_cmd_addr(addr), .ram_wr_cmd_data(data),
    .ram_wr_cmd_strb(strb), .ram_wr_cmd_en(en1), .ram_wr_cmd_last(last), .ram_wr_cmd_ready(ready1),
    .rd_addr(rd_addr), .rd_data(rd_data1), .wr_done_valid(done1), .wr_done_id(did1),
    .beat_count(bc1), .fifo_level(lvl1));
  always @(negedge clk) begin
    if (done0) dc0++;
    if (done1) dc1++;
    if (int'(lvl0) > ml0) ml0 = int'(lvl0);
    if (int'(lvl1) > ml1) ml1 = int'(lvl1);
  end
  // free-running period-4 phase expected for u1's stall generator
  always @(posedge clk or negedge rst_n) sc <= !rst_n ? 0 : (sc + 1) % 4;
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [7:0]  id;
    logic [31:0] word;
    logic        done;
    logic [7:0]  done_id;
  } vec_t;
  vec_t tv[7];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic peek0(input logic [15:0] a, input logic [31:0] exp, input string nm);
    rd_addr = a;
    #1 chk(nm, rd_data0, exp);
  endtask
  task automatic burst0(input logic [15:0] base, input logic [31:0] d0, input int n, input logic [7:0] bid, input logic fin);
    for (int i = 0; i < n; i++) begin
      addr = base + 16'(4 * i);
      data = d0 + 32'(i);
      strb = 4'hF;
      id   = bid;
      last = fin && i == n - 1;
      en0  = 1'b1;
      if (!ready0) drops++;
      @(posedge clk);
      #1;
    end
    en0 = 1'b0;
  endtask
  initial begin
    tv[0] = '{16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 8'h5A, 32'hDEADBEEF, 1'b1, 8'h5A};
    tv[1] = '{16'h0020, 32'h11223344, 4'hF, 1'b0, 8'h01, 32'h11223344, 1'b0, 8'h5A};
    tv[2] = '{16'h0020, 32'hAABBCCDD, 4'h5, 1'b1, 8'h02, 32'h11BB33DD, 1'b1, 8'h02};
    tv[3] = '{16'h0022, 32'h55667788, 4'h8, 1'b0, 8'h03, 32'h55BB33DD, 1'b0, 8'h02};
    tv[4] = '{16'h0030, 32'h12345678, 4'hF, 1'b0, 8'h04, 32'h12345678, 1'b0, 8'h02};
    tv[5] = '{16'h0030, 32'hFFFFFFFF, 4'h0, 1'b1, 8'h7E, 32'h12345678, 1'b1, 8'h7E};
    tv[6] = '{16'hFFFC, 32'hA5A5A5A5, 4'hF, 1'b1, 8'hFF, 32'hA5A5A5A5, 1'b1, 8'hFF};
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; id = '0; addr = '0; data = '0; strb = '0; last = 1'b0; rd_addr = '0;
    #3;
    chk("rst_level", lvl0, 0);
    chk("rst_beat_count", bc0, 0);
    chk("rst_done_valid", done0, 0);
    chk("rst_done_id", did0, 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_ready", ready0, 1);
    for (int i = 0; i < 7; i++) begin
      addr = tv[i].addr; data = tv[i].data; strb = tv[i].strb; last = tv[i].last; id = tv[i].id; en0 = 1'b1;
      chk($sformatf("v%0d_ready", i), ready0, 1);
      @(posedge clk);
      #1 en0 = 1'b0;
      chk($sformatf("v%0d_level_push", i), lvl0, 1);
      @(posedge clk);
      #1 peek0(tv[i].addr, tv[i].word, $sformatf("v%0d_word", i));
      chk($sformatf("v%0d_done", i), done0, tv[i].done);
      chk($sformatf("v%0d_done_id", i), did0, tv[i].done_id);
      chk($sformatf("v%0d_beat_count", i), bc0, i + 1);
      chk($sformatf("v%0d_level_pop", i), lvl0, 0);
    end
    @(posedge clk);
    #1 chk("done_one_cycle", done0, 0);
    drops = 0;
    dc0 = 0;
    burst0(16'h0100, 32'd0, 8, 8'h33, 1'b1);
    chk("burst_ready_drops", drops, 0);
    chk("burst_no_early_done", dc0, 0);
    @(posedge clk);
    #1 chk("burst_done", done0, 1);
    chk("burst_done_id", did0, 8'h33);
    chk("burst_beat_count", bc0, 15);
    for (int i = 0; i < 8; i++) peek0(16'h0100 + 16'(4 * i), 32'(i), $sformatf("burst_word%0d", i));
    @(posedge clk);
    #1 chk("burst_done_pulses", dc0, 1);
    chk("burst_max_level", ml0 <= 1, 1);
    begin
      int k = 0, cyc = 0;
      logic acc;
      dc1 = 0;
      addr = 16'h0200; data = 32'hB0000000; strb = 4'hF; last = 1'b0; id = 8'h00; en1 = 1'b1;
      while (k < 16 && cyc < 200) begin
        chk($sformatf("stall_ready_c%0d", cyc), ready1, sc < 2);
        acc = ready1;
        @(posedge clk);
        #1 cyc++;
        if (acc) begin
          k++;
          addr = 16'h0200 + 16'(4 * k); data = 32'hB0000000 + 32'(k); last = k == 15; id = 8'(k);
        end
      end
      en1 = 1'b0;
      chk("stall_all_accepted", k, 16);
      @(posedge clk);
      #1 chk("stall_beat_count", bc1, 16);
      chk("stall_done_id", did1, 8'd15);
      for (int i = 0; i < 16; i++) begin
        rd_addr = 16'h0200 + 16'(4 * i);
        #1 chk($sformatf("stall_word%0d", i), rd_data1, 32'hB0000000 + 32'(i));
      end
      @(posedge clk);
      #1 chk("stall_done_pulses", dc1, 1);
      chk("stall_max_level", ml1 <= 1, 1);
    end
    drops = 0;
    burst0(16'h0300, 32'hCAFE0000, 8, 8'h08, 1'b1);
    @(posedge clk);
    #1 burst0(16'h0300, 32'hD0000000, 3, 8'h09, 1'b0);
    chk("mid_level", lvl0, 1);
    #2 rst_n = 1'b0;
    #1 chk("arst_level", lvl0, 0);
    chk("arst_beat_count", bc0, 0);
    chk("arst_done_valid", done0, 0);
    chk("arst_done_id", did0, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_ready", ready0, 1);
    chk("post_rst_beat_count", bc0, 0);
    peek0(16'h0300, 32'hD0000000, "rst_committed0");
    peek0(16'h0304, 32'hD0000001, "rst_committed1");
    peek0(16'h0308, 32'hCAFE0002, "rst_discarded2");
    peek0(16'h031C, 32'hCAFE0007, "rst_untouched7");
    peek0(16'h0010, 32'hDEADBEEF, "rst_retained");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
